// File: rtl/pio_in_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pio_in_pkg
// Purpose  : Shared register-map constants for the debounced input PIO.
// Revision : 1.0  initial release
// ============================================================================
package pio_in_pkg;

    // Avalon word addresses of the PIO register file
    localparam logic [2:0] ADDR_DATA  = 3'd0;  // debounced value (RO)
    localparam logic [2:0] ADDR_RAW   = 3'd1;  // synchronised value (RO)
    localparam logic [2:0] ADDR_MASK  = 3'd2;  // irq mask (RW)
    localparam logic [2:0] ADDR_EDGE  = 3'd3;  // edge capture (R / W1C)
    localparam logic [2:0] ADDR_RISE  = 3'd4;  // rising-edge enable (RW)
    localparam logic [2:0] ADDR_FALL  = 3'd5;  // falling-edge enable (RW)
    localparam logic [2:0] ADDR_DBLIM = 3'd6;  // debounce limit (RW)

endpackage : pio_in_pkg
`default_nettype wire

// File: rtl/pio_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : pio_debounce_bit
// Purpose  : One input bit: multi-flop synchroniser followed by a
//            consecutive-mismatch debounce counter and the stable flop.
// Revision : 1.0  initial release
// ============================================================================
module pio_debounce_bit #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            d_async,
    input  logic [DB_W-1:0] limit,
    output logic            q_stable,
    output logic            q_sync
);

    localparam logic [DB_W-1:0] c_one = DB_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_cnt;
    logic                   r_stable;
    logic [DB_W-1:0]        w_last;
    logic                   w_mismatch;

    // A limit of 0 behaves as 1, so the last counted cycle index is limit-1
    // clamped at 0. The live limit is used, so a mid-count write applies at once.
    assign w_last     = (limit == '0) ? '0 : (limit - c_one);
    assign w_mismatch = r_sync[SYNC_STAGES-1] ^ r_stable;

    // Synchronise the raw input and accept a new level after N mismatch cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (r_cnt >= w_last) begin
                r_stable <= r_sync[SYNC_STAGES-1];
                r_cnt    <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + c_one;
            end
        end
    end

    assign q_stable = r_stable;
    assign q_sync   = r_sync[SYNC_STAGES-1];

endmodule : pio_debounce_bit
`default_nettype wire

// File: rtl/pio_in_debounced.sv
`default_nettype none
// ============================================================================
// Module   : pio_in_debounced
// Purpose  : Avalon-MM input PIO with per-bit synchroniser, software-timed
//            debounce, per-bit rise/fall edge select, W1C edge capture and
//            a masked level interrupt.
// Revision : 1.0  initial release
// ============================================================================
module pio_in_debounced
    import pio_in_pkg::*;
#(
    parameter int              WIDTH       = 10,
    parameter int              SYNC_STAGES = 2,
    parameter int              DB_W        = 16,
    parameter logic [DB_W-1:0] DB_DEFAULT  = 16'd50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [DB_W-1:0]  r_db_limit;
    logic [31:0]      r_readdata;

    // One synchroniser + debouncer per input bit
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_W        (DB_W)
        ) u_db (
            .clk      (clk),
            .reset    (reset),
            .d_async  (in_port[gi]),
            .limit    (r_db_limit),
            .q_stable (w_stable[gi]),
            .q_sync   (w_sync[gi])
        );
    end

    assign w_wr = chipselect && !write_n;

    // Qualified edges on the debounced value
    assign w_ev = ( w_stable & ~r_stable_d & r_rise_en)
                | (~w_stable &  r_stable_d & r_fall_en);

    assign w_clr = (w_wr && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    // Upper write-data bits have no storage behind them
    assign w_unused_wdata = ^writedata;

    // Read multiplexer; reads have no side effects
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:  w_rdata = 32'(w_stable);
            ADDR_RAW:   w_rdata = 32'(w_sync);
            ADDR_MASK:  w_rdata = 32'(r_irq_mask);
            ADDR_EDGE:  w_rdata = 32'(r_edge_capture);
            ADDR_RISE:  w_rdata = 32'(r_rise_en);
            ADDR_FALL:  w_rdata = 32'(r_fall_en);
            ADDR_DBLIM: w_rdata = 32'(r_db_limit);
            default:    w_rdata = '0;
        endcase
    end

    // Register file, edge history, W1C capture (set beats clear) and read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d     <= '0;
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
            r_rise_en      <= '1;
            r_fall_en      <= '1;
            r_db_limit     <= DB_DEFAULT;
            r_readdata     <= '0;
        end else begin
            r_stable_d     <= w_stable;
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_ev;
            r_readdata     <= w_rdata;
            if (w_wr) begin
                case (address)
                    ADDR_MASK:  r_irq_mask <= writedata[WIDTH-1:0];
                    ADDR_RISE:  r_rise_en  <= writedata[WIDTH-1:0];
                    ADDR_FALL:  r_fall_en  <= writedata[WIDTH-1:0];
                    ADDR_DBLIM: r_db_limit <= writedata[DB_W-1:0];
                    default:    ;
                endcase
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_capture & r_irq_mask);

endmodule : pio_in_debounced
`default_nettype wire

// File: tb/tb_pio_in_debounced.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_in_debounced
// Purpose  : Directed, table-driven self-checking bench for pio_in_debounced.
// Revision : 1.0  initial release
// ============================================================================
module tb_pio_in_debounced;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    pio_in_debounced #(
        .WIDTH       (10),
        .SYNC_STAGES (2),
        .DB_W        (16),
        .DB_DEFAULT  (16'd50000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick(1);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        logic [31:0] d;

        // reads after reset, then write/readback of each register
        vecs[0]  = '{3'd0, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{3'd1, 1'b0, 32'h0,         32'h0};
        vecs[2]  = '{3'd2, 1'b0, 32'h0,         32'h0};
        vecs[3]  = '{3'd3, 1'b0, 32'h0,         32'h0};
        vecs[4]  = '{3'd4, 1'b0, 32'h0,         32'h3FF};
        vecs[5]  = '{3'd5, 1'b0, 32'h0,         32'h3FF};
        vecs[6]  = '{3'd6, 1'b0, 32'h0,         32'd50000};
        vecs[7]  = '{3'd7, 1'b0, 32'h0,         32'h0};
        vecs[8]  = '{3'd2, 1'b1, 32'hFFFF_FC05, 32'h005};
        vecs[9]  = '{3'd6, 1'b1, 32'h0001_2345, 32'h2345};
        vecs[10] = '{3'd7, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[11] = '{3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{3'd4, 1'b1, 32'h0000_0155, 32'h155};
        vecs[13] = '{3'd3, 1'b1, 32'h0000_03FF, 32'h0};

        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        tick(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), d, vecs[i].exp);
        end
        check("vec_irq_idle", {31'h0, irq}, 32'h0);
        wr(3'd2, 32'h0);
        wr(3'd4, 32'h3FF);

        // Bit 0 rise with db_limit=4: raw after 2 cycles, data after 6
        wr(3'd6, 32'd4);
        address = 3'd1;
        in_port[0] = 1'b1;
        tick(2);
        check("raw0_early", readdata, 32'h0);
        tick(1);
        check("raw0_set", readdata, 32'h1);
        address = 3'd0;
        tick(3);
        check("data0_early", readdata, 32'h0);
        tick(1);
        check("data0_set", readdata, 32'h1);
        rd(3'd3, d);
        check("edge0_set", d, 32'h1);
        check("irq_masked", {31'h0, irq}, 32'h0);
        wr(3'd2, 32'h1);
        check("irq_after_mask", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h1);
        check("irq_after_clear", {31'h0, irq}, 32'h0);
        wr(3'd2, 32'h0);

        // 3-cycle glitch on bit 3 must be rejected
        wr(3'd2, 32'h008);
        in_port[3] = 1'b1;
        tick(3);
        in_port[3] = 1'b0;
        tick(10);
        rd(3'd0, d);
        check("glitch_data", d, 32'h001);
        rd(3'd3, d);
        check("glitch_edge", d, 32'h0);
        check("glitch_irq", {31'h0, irq}, 32'h0);
        wr(3'd2, 32'h0);

        // Fall-only capture on bit 1
        wr(3'd4, 32'h0);
        wr(3'd5, 32'h002);
        in_port[1] = 1'b1;
        tick(12);
        rd(3'd3, d);
        check("rise_ignored", d, 32'h0);
        rd(3'd0, d);
        check("bit1_high", d, 32'h003);
        in_port[1] = 1'b0;
        tick(12);
        rd(3'd3, d);
        check("fall_captured", d, 32'h002);

        // W1C and set-beats-clear
        wr(3'd3, 32'h3FF);
        rd(3'd3, d);
        check("w1c_all", d, 32'h0);
        wr(3'd4, 32'h00C);
        in_port[3:2] = 2'b11;
        tick(12);
        rd(3'd3, d);
        check("edge_0c", d, 32'h00C);
        wr(3'd3, 32'h004);
        rd(3'd3, d);
        check("w1c_bit2", d, 32'h008);
        wr(3'd4, 32'h00E);
        in_port[1] = 1'b1;
        tick(6);
        wr(3'd3, 32'h002);
        rd(3'd3, d);
        check("set_beats_clr", d, 32'h00A);

        // Reset while bit 5 is at count 3 of 4
        wr(3'd4, 32'h3FF);
        wr(3'd5, 32'h3FF);
        wr(3'd3, 32'h3FF);
        rd(3'd4, d);
        check("pre_reset_rise", d, 32'h3FF);
        in_port[5] = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("reset_mid_rd", readdata, 32'h0);
        check("reset_mid_irq", {31'h0, irq}, 32'h0);
        rd(3'd0, d);
        check("post_reset_data", d, 32'h0);
        wr(3'd6, 32'd4);
        tick(3);
        rd(3'd0, d);
        check("full_db_pending", d, 32'h0);
        rd(3'd0, d);
        check("full_db_done", d, 32'h02F);
        rd(3'd3, d);
        check("post_reset_edges", d, 32'h02F);
        check("post_reset_irq", {31'h0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pio_in_debounced
`default_nettype wire
